// File: rtl/display_scan.sv
// ============================================================================
//  Module   : display_scan
//  Brief    : 4-digit multiplexed 7-segment scanner with per-slot anti-ghost blanking,
//             a per-frame snapshot of the input, and optional blink (macro DISPLAY_BLINK_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan #(
   parameter int DIV_SCAN     = 25000,
   parameter int BLANK_CYCLES = 500,
   parameter int BLINK_FRAMES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [27:0] display_in,
   input  logic        blink,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_done
);

   localparam int CW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [CW-1:0] c_DIV_LAST   = CW'(DIV_SCAN - 1);
   localparam logic [BW-1:0] c_BLANK_LAST = BW'(BLANK_CYCLES - 1);

   typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [BW-1:0]   r_bcnt;
   logic [1:0]      r_idx;
   logic [27:0]     r_snap;
   logic            r_armed;
   logic [3:0]      r_an;
   logic [6:0]      r_seg;
   logic            r_frame_done;

   logic            w_tick;
   logic            w_wrap;
   logic            w_vis_nxt;
   logic [1:0]      w_sel_idx;
   logic [27:0]     w_sel_pat;
   logic [6:0]      w_pat;
   logic [3:0]      w_an_show;
   logic [6:0]      w_seg_show;

   assign w_tick = (r_cnt == c_DIV_LAST);
   assign w_wrap = w_tick && (r_idx == 2'd3);

`ifdef DISPLAY_BLINK_EN
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [FW-1:0] c_BF = FW'(BLINK_FRAMES);

   logic [FW-1:0] r_fcnt;
   logic          r_vis;
   logic [FW-1:0] w_fcnt_nxt;

   // r_fcnt counts frames started under blink; the phase flips when a new frame would exceed BLINK_FRAMES
   assign w_fcnt_nxt = (r_fcnt == c_BF) ? FW'(1) : r_fcnt + FW'(1);
   assign w_vis_nxt  = !blink ? 1'b1 :
                       (w_wrap && (r_fcnt == c_BF)) ? ~r_vis : r_vis;

   always_ff @(posedge clk) begin
      if (!rst_n || !blink) begin
         r_fcnt <= '0;
         r_vis  <= 1'b1;
      end else if (w_wrap) begin
         r_fcnt <= w_fcnt_nxt;
         r_vis  <= w_vis_nxt;
      end
   end
`else
   logic w_unused_blink;
   assign w_unused_blink = blink;
   assign w_vis_nxt      = 1'b1;
`endif

   // Digit that will be visible after this edge: the incoming slot on a tick, else the current one
   assign w_sel_idx = w_tick ? (r_idx + 2'd1) : r_idx;
   assign w_sel_pat = w_wrap ? display_in : r_snap;

   always_comb begin
      w_pat = 7'h00;
      case (w_sel_idx)
         2'd0: w_pat = w_sel_pat[6:0];
         2'd1: w_pat = w_sel_pat[13:7];
         2'd2: w_pat = w_sel_pat[20:14];
         2'd3: w_pat = w_sel_pat[27:21];
         default: w_pat = 7'h00;
      endcase
   end

   assign w_an_show  = w_vis_nxt ? ~(4'b0001 << w_sel_idx) : 4'b1111;
   assign w_seg_show = w_vis_nxt ? ~w_pat : 7'h7F;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_idx        <= 2'd3;
         r_state      <= ST_BLANK;
         r_bcnt       <= '0;
         r_snap       <= '0;
         r_armed      <= 1'b0;
         r_an         <= 4'b1111;
         r_seg        <= 7'h7F;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_wrap;
         if (w_tick) begin
            r_cnt   <= '0;
            r_idx   <= r_idx + 2'd1;
            r_armed <= 1'b1;
            if (w_wrap) begin
               r_snap <= display_in;
            end
            if (BLANK_CYCLES == 0) begin
               r_state <= ST_SHOW;
               r_an    <= w_an_show;
               r_seg   <= w_seg_show;
            end else begin
               r_state <= ST_BLANK;
               r_bcnt  <= '0;
               r_an    <= 4'b1111;
               r_seg   <= 7'h7F;
            end
         end else begin
            r_cnt <= r_cnt + CW'(1);
            case (r_state)
               ST_BLANK: begin
                  // Stay dark after reset until the first tick selects digit 0
                  if (r_armed && (r_bcnt == c_BLANK_LAST)) begin
                     r_state <= ST_SHOW;
                     r_an    <= w_an_show;
                     r_seg   <= w_seg_show;
                  end else begin
                     r_bcnt  <= r_bcnt + BW'(1);
                  end
               end
               ST_SHOW: begin
                  r_an  <= w_an_show;
                  r_seg <= w_seg_show;
               end
            endcase
         end
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_display_scan.sv
// ============================================================================
//  Module   : tb_display_scan
//  Brief    : Scoreboard bench for display_scan (DIV_SCAN=8, BLINK_FRAMES=2) with
//             BLANK_CYCLES=2 and BLANK_CYCLES=0 instances driven in parallel.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [27:0] display_in = '0;
   logic        blink = 1'b0;
   logic [3:0]  an, an0;
   logic [6:0]  seg, seg0;
   logic        frame_done, frame_done0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       fd;
      logic [3:0] an0;
      logic [6:0] seg0;
      logic       fd0;
   } exp_t;

   exp_t q[$];

   // model state: edges since reset release, and the frame snapshot
   int          m_k = 0;
   logic [27:0] m_snap = '0;

   always #5 clk = ~clk;

   display_scan #(.DIV_SCAN(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .display_in(display_in), .blink(blink),
      .an(an), .seg(seg), .frame_done(frame_done)
   );

   display_scan #(.DIV_SCAN(8), .BLANK_CYCLES(0), .BLINK_FRAMES(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .display_in(display_in), .blink(blink),
      .an(an0), .seg(seg0), .frame_done(frame_done0)
   );

   function automatic logic [6:0] f_seg(input logic [27:0] s, input int i);
      logic [27:0] t;
      t = s >> (7 * i);
      return ~t[6:0];
   endfunction

   // Drive one clock's inputs and push the outputs expected after the next edge
   task automatic cyc(input logic rn, input logic [27:0] d, input logic bl);
      exp_t e;
      int   p, slot, pos, idx;
      @(negedge clk);
      rst_n      = rn;
      display_in = d;
      blink      = bl;
      e.an = 4'b1111; e.seg = 7'h7F; e.fd = 1'b0;
      e.an0 = 4'b1111; e.seg0 = 7'h7F; e.fd0 = 1'b0;
      if (!rn) begin
         m_k    = 0;
         m_snap = '0;
      end else begin
         m_k = m_k + 1;
         if (m_k >= 8) begin
            p    = m_k - 8;
            slot = p / 8;
            pos  = p % 8;
            idx  = slot % 4;
            if (pos == 0 && idx == 0) begin
               m_snap = d;
               e.fd   = 1'b1;
               e.fd0  = 1'b1;
            end
            e.an0  = ~(4'b0001 << idx);
            e.seg0 = f_seg(m_snap, idx);
            if (pos >= 2) begin
               e.an  = e.an0;
               e.seg = e.seg0;
            end
         end
      end
      q.push_back(e);
   endtask

   // Monitor: one output vector per clock, compared against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({an, seg, frame_done} !== {e.an, e.seg, e.fd}) begin
               errors++;
               $display("FAIL scan_b2 t=%0t got an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                        $time, an, seg, frame_done, e.an, e.seg, e.fd);
            end
            checks++;
            if ({an0, seg0, frame_done0} !== {e.an0, e.seg0, e.fd0}) begin
               errors++;
               $display("FAIL scan_b0 t=%0t got an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                        $time, an0, seg0, frame_done0, e.an0, e.seg0, e.fd0);
            end
         end
      end
   end

   initial begin
      logic [27:0] d1, d2, d3;
      d1 = 28'h0EFF3F7;
      d2 = 28'h5B4F666;
      d3 = 28'h7F06DB4;

      repeat (3) cyc(1'b0, d1, 1'b0);

      // first frame with d1; switch to d2 midway through the idx=1 slot
      for (int i = 0; i < 18; i++) cyc(1'b1, d1, 1'b0);
      for (int i = 0; i < 90; i++) cyc(1'b1, d2, 1'b0);

      // blink has no effect in the default build
      for (int i = 0; i < 40; i++) cyc(1'b1, d3, 1'b1);

      // run to mid-SHOW of digit 2, then reset there
      for (int i = 0; i < 40; i++) begin
         if (m_k >= 8 && ((m_k - 8) / 8) % 4 == 2 && (m_k - 8) % 8 == 4) break;
         cyc(1'b1, d3, 1'b0);
      end
      repeat (2) cyc(1'b0, d3, 1'b0);

      // all-zero input: digits enabled with every segment dark
      for (int i = 0; i < 45; i++) cyc(1'b1, 28'h0, 1'b0);
      for (int i = 0; i < 40; i++) cyc(1'b1, d1, 1'b0);

      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d pending expected 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
